mem_bist_ctrl: RTL



---
 rtl/mem_bist_pkg.sv | 20 ++
 rtl/mem_bist_delay.sv | 37 +++
 rtl/mem_bist_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and the data-pattern generator for the memory BIST controller.
// Patterns are built at MAX_W bits. Callers truncate the result to their own width.
package mem_bist_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_t;
  typedef enum logic [1:0] {PAT_ADDR, PAT_INV, PAT_CHK, PAT_ZERO} pattern_t;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] expected_data(input logic [MAX_W-1:0] addr,
                                                     input pattern_t pat);
    case (pat)
      PAT_ADDR: return addr;
      PAT_INV:  return ~addr;
      PAT_CHK:  return addr[0] ? {(MAX_W/8){8'hAA}} : {(MAX_W/8){8'h55}};
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_delay.sv
// This is a DEPTH-stage shift line of {valid, addr}. It aligns each read address with its returning data.
// The clr input drops only the valid bits. Stale addresses are harmless without a valid bit.
module mem_bist_delay #(
  parameter int N     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [N-1:0] in_addr,
  output logic         out_vld,
  output logic [N-1:0] out_addr
);

  logic [DEPTH-1:0]        vld;
  logic [DEPTH-1:0][N-1:0] adr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      adr <= '0;
    end else if (en) begin
      vld[0] <= in_vld && !clr;
      adr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1] && !clr;
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_addr = adr[DEPTH-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// This controller writes a pattern to every address, then reads each address back and checks it.
// It records the error count and the first failing address and data.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int N        = 8,
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   pattern_sel,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N-1:0] fail_addr,
  output logic [N-1:0] fail_data,
  output logic [N:0]   err_count
);

  localparam logic [N-1:0] LAST = '1;
  localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t          state, nxt;
  logic [N-1:0]    cnt;
  logic [DW-1:0]   dcnt;
  pattern_t        pat;
  logic            accept;
  logic            d_vld, cmp_vld, mismatch;
  logic [N-1:0]    d_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // The memory outputs decode directly from the state. Reset therefore forces them low at once.
  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start && !abort) begin
        accept = 1'b1;
        nxt    = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_wdata = N'(expected_data(MAX_W'(cnt), pat));
        busy      = 1'b1;
        if (abort)            nxt = ST_IDLE;
        else if (cnt == LAST) nxt = ST_READ;
      end
      ST_READ: begin
        mem_addr = cnt;
        busy     = 1'b1;
        if (abort)            nxt = ST_IDLE;
        else if (cnt == LAST) nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (abort)                          nxt = ST_IDLE;
        else if (dcnt == DW'(READ_LAT - 1)) nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (abort) nxt = ST_IDLE;
        else if (start) begin
          accept = 1'b1;
          nxt    = ST_WRITE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  mem_bist_delay #(.N(N), .DEPTH(READ_LAT)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .clr      (abort),
    .in_vld   (state == ST_READ),
    .in_addr  (cnt),
    .out_vld  (d_vld),
    .out_addr (d_addr)
  );

  assign cmp_vld  = d_vld && !abort;
  assign mismatch = mem_rdata != N'(expected_data(MAX_W'(d_addr), pat));
  assign pass     = done && (err_count == '0);

  // cnt wraps from LAST back to 0. That wrap starts the read pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      dcnt      <= '0;
      pat       <= PAT_ADDR;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        pat       <= pattern_t'(pattern_sel);
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (state == ST_WRITE || state == ST_READ) begin
        cnt <= cnt + 1'b1;
      end
      dcnt <= (state == ST_DRAIN) ? dcnt + 1'b1 : '0;
      if (cmp_vld && mismatch) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr <= d_addr;
          fail_data <= mem_rdata;
        end
      end
    end
  end

endmodule
